// File: rtl/mux_scan_if.sv
// Channel-data / select bus for the scanning multiplexer.
// The master drives the channel data and controls; the slave returns the tagged output.
interface mux_scan_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 3
);
  logic [N*W-1:0] x;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           en;
  logic [W-1:0]   o;
  logic [SW-1:0]  ch;
  logic           o_valid;
  logic           wrap;

  modport master (
    output x, sel, mode, en,
    input  o, ch, o_valid, wrap
  );

  modport slave (
    input  x, sel, mode, en,
    output o, ch, o_valid, wrap
  );
endinterface

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with a manual select mode and an auto-scan mode
// that dwells DWELL cycles per channel; o and ch are always updated together.
module mux_scan #(
  parameter int unsigned W     = 4,
  parameter int unsigned N     = 8,
  parameter int unsigned SW    = 3,
  parameter int unsigned DWELL = 4
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);

  localparam int unsigned CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);

  typedef enum logic {ST_MANUAL, ST_SCAN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_cur;
  logic [SW-1:0] r_ch, w_ch_nxt;
  logic [W-1:0]  r_o, w_o_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_wrap, w_wrap_nxt;
  logic          w_sel_ok;

  assign w_sel_ok = 32'(bus.sel) < N;

  // Next-state and next-output decode; the mode input picks the behaviour of this edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_o_nxt     = r_o;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    // Entering scan from manual always starts a fresh, full dwell
    w_cnt_cur   = (r_state == ST_SCAN) ? r_cnt : '0;

    if (bus.en) begin
      w_state_nxt = bus.mode ? ST_SCAN : ST_MANUAL;
      unique case (w_state_nxt)
        ST_SCAN: begin
          w_valid_nxt = 1'b1;
          if (w_cnt_cur == CNT_LAST) begin
            w_cnt_nxt  = '0;
            w_ch_nxt   = (r_ch == CH_LAST) ? '0 : r_ch + SW'(1);
            w_wrap_nxt = (r_ch == CH_LAST);
          end else begin
            w_cnt_nxt = w_cnt_cur + CW'(1);
          end
          w_o_nxt = bus.x[32'(w_ch_nxt)*W +: W];
        end
        default: begin
          w_cnt_nxt = '0;
          if (w_sel_ok) begin
            w_ch_nxt    = bus.sel;
            w_valid_nxt = 1'b1;
            w_o_nxt     = bus.x[32'(bus.sel)*W +: W];
          end else begin
            w_valid_nxt = 1'b0;
            w_o_nxt     = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_MANUAL;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_o     <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
      r_o     <= w_o_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.o       = r_o;
  assign bus.ch      = r_ch;
  assign bus.o_valid = r_valid;
  assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: an 8-channel/DWELL=4 and a 6-channel/DWELL=1 instance
// share one random stimulus stream and are checked against a sweep-position model.
module tb_mux_scan;

  typedef struct packed {
    logic [3:0] o;
    logic [2:0] ch;
    logic       v;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t q8[$];
  exp_t q6[$];

  // Model: position within a full sweep; channel = pos / dwell
  int   m_ch[2];
  int   m_pos[2];
  exp_t m_last[2];

  always #5 clk = ~clk;

  mux_scan_if #(.W(4), .N(8), .SW(3)) bus8();
  mux_scan_if #(.W(4), .N(6), .SW(3)) bus6();

  mux_scan #(.W(4), .N(8), .SW(3), .DWELL(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  mux_scan #(.W(4), .N(6), .SW(3), .DWELL(1)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  task automatic cmp(input string nm, input exp_t e, input exp_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got o=%h ch=%0d v=%b wrap=%b, expected o=%h ch=%0d v=%b wrap=%b",
               nm, $time, a.o, a.ch, a.v, a.wrap, e.o, e.ch, e.v, e.wrap);
    end
  endtask

  function automatic exp_t mstep(input int d, input int n, input int dw, input logic [31:0] xv,
                                 input int s, input bit m, input bit e);
    exp_t r;
    r = m_last[d];
    if (!e) begin
      r.wrap = 1'b0;
    end else if (!m) begin
      if (s < n) begin
        m_ch[d] = s;
        r.o     = xv[s*4 +: 4];
        r.v     = 1'b1;
      end else begin
        r.o = 4'h0;
        r.v = 1'b0;
      end
      r.ch     = 3'(m_ch[d]);
      r.wrap   = 1'b0;
      m_pos[d] = m_ch[d] * dw;
    end else begin
      m_pos[d] = (m_pos[d] + 1) % (n * dw);
      m_ch[d]  = m_pos[d] / dw;
      r.ch     = 3'(m_ch[d]);
      r.o      = xv[m_ch[d]*4 +: 4];
      r.v      = 1'b1;
      r.wrap   = (m_pos[d] == 0);
    end
    m_last[d] = r;
    return r;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_ch[d]   = 0;
      m_pos[d]  = 0;
      m_last[d] = '0;
    end
    q8.delete();
    q6.delete();
  endtask

  // Drive one cycle of inputs (called at a falling edge) and queue the expected result
  task automatic cyc(input logic [31:0] xv, input int s, input bit m, input bit e);
    bus8.x    = xv;
    bus6.x    = xv[23:0];
    bus8.sel  = 3'(s);
    bus6.sel  = 3'(s);
    bus8.mode = m;
    bus6.mode = m;
    bus8.en   = e;
    bus6.en   = e;
    q8.push_back(mstep(0, 8, 4, xv, s, m, e));
    q6.push_back(mstep(1, 6, 1, xv, s, m, e));
    @(negedge clk);
  endtask

  task automatic chk_rst(input string nm);
    cmp({nm, "_n8"}, '0, {bus8.o, bus8.ch, bus8.o_valid, bus8.wrap});
    cmp({nm, "_n6"}, '0, {bus6.o, bus6.ch, bus6.o_valid, bus6.wrap});
  endtask

  // Monitor: every clock out of reset must have a queued expectation
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (q8.size() == 0 || q6.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty t=%0t: got no expected entry, required one per cycle", $time);
      end else begin
        cmp("sb_n8", q8.pop_front(), {bus8.o, bus8.ch, bus8.o_valid, bus8.wrap});
        cmp("sb_n6", q6.pop_front(), {bus6.o, bus6.ch, bus6.o_valid, bus6.wrap});
      end
    end
  end

  initial begin
    logic [31:0] xr;
    bit          md;
    mreset();
    bus8.x = $urandom(); bus6.x = bus8.x[23:0];
    bus8.sel = 3'd3; bus6.sel = 3'd3;
    bus8.mode = 1'b1; bus6.mode = 1'b1;
    bus8.en = 1'b1; bus6.en = 1'b1;

    // Reset held with scan mode and live data
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus8.x = $urandom(); bus6.x = bus8.x[23:0];
      chk_rst("reset_hold");
    end
    rst_n = 1'b1;
    cyc(32'h76543210, 0, 1'b0, 1'b1);

    // Manual sweep across every select value (6 and 7 are illegal on the 6-channel unit)
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < 10; k++) cyc(32'h76543210, s, 1'b0, 1'b1);

    // Scan from ch=0 through a complete sweep plus a bit
    cyc(32'h76543210, 0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) cyc(32'h76543210, 0, 1'b1, 1'b1);

    // Freeze mid-dwell with changing data, then resume
    for (int k = 0; k < 2; k++) cyc(32'h76543210, 0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) cyc($urandom(), 0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(32'hFEDCBA98, 0, 1'b1, 1'b1);

    // Scan to manual mid-dwell
    cyc(32'h76543210, 0, 1'b1, 1'b1);
    cyc(32'h76543210, 2, 1'b0, 1'b1);
    cyc(32'h76543210, 7, 1'b0, 1'b1);
    cyc(32'h76543210, 6, 1'b1, 1'b1);

    // Random traffic with occasional mode flips and enable gaps
    md = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      xr = $urandom();
      cyc(xr, int'($urandom_range(0, 7)), md, ($urandom_range(0, 7) != 0));
    end

    // Asynchronous reset asserted between clock edges mid-scan
    for (int k = 0; k < 6; k++) cyc($urandom(), 0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("async_reset");
    mreset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_rst("reset_hold2");
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) cyc(32'h76543210, 4, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
